// File: rtl/ram_port_arbiter_if.sv
// Bundle of client-side and RAM-side signals for the RAM port arbiter.
//
// Handshake: a client holds req_ren/req_wen (plus addr/store) asserted while
// req_wait is 1; the cycle its req_wait lane drops to 0 is the completion
// cycle (read data valid on its req_load lane, req_err set if it failed).
// On the RAM side ramREN/ramWEN are held until ramstate reports ACCESS or
// ERROR; ramstate is the RAM's ready/status indication.
interface ram_port_arbiter_if #(
  parameter int REQS   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int ID_W = (REQS > 1) ? $clog2(REQS) : 1;

  // client side
  logic [REQS-1:0]        req_ren;
  logic [REQS-1:0]        req_wen;
  logic [REQS*ADDR_W-1:0] req_addr;
  logic [REQS*DATA_W-1:0] req_store;
  logic [REQS*DATA_W-1:0] req_load;
  logic [REQS-1:0]        req_wait;
  logic [REQS-1:0]        req_err;

  // RAM side
  logic                   ramREN;
  logic                   ramWEN;
  logic [ADDR_W-1:0]      ramaddr;
  logic [DATA_W-1:0]      ramstore;
  logic [DATA_W-1:0]      ramload;
  logic [1:0]             ramstate;

  // grant status and debug visibility of internal state
  logic                   gnt_valid;
  logic [ID_W-1:0]        gnt_id;
  logic [1:0]             dbg_state;
  logic [ID_W-1:0]        dbg_ptr;

  modport master (
    input  req_ren, req_wen, req_addr, req_store, ramload, ramstate,
    output req_load, req_wait, req_err, ramREN, ramWEN, ramaddr, ramstore,
           gnt_valid, gnt_id, dbg_state, dbg_ptr
  );

  modport slave (
    output req_ren, req_wen, req_addr, req_store, ramload, ramstate,
    input  req_load, req_wait, req_err, ramREN, ramWEN, ramaddr, ramstore,
           gnt_valid, gnt_id, dbg_state, dbg_ptr
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among REQS requesters, with a
// watchdog that releases a grant the RAM never completes.
module ram_port_arbiter #(
  parameter int REQS    = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                CLK,
  input  logic                RST,
  ram_port_arbiter_if.master  bus
);
  localparam int ID_W = (REQS > 1) ? $clog2(REQS) : 1;
  localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] gnt_id_q, gnt_id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;

  logic [REQS-1:0] active;
  logic            found;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] ptr_next;
  logic            g_active;
  logic            wd_expire;
  int              idx;

  assign active = bus.req_ren | bus.req_wen;

  // The just-served requester gets lowest priority on the next scan.
  assign ptr_next = (gnt_id_q == ID_W'(REQS - 1)) ? '0 : gnt_id_q + 1'b1;

  assign g_active  = active[gnt_id_q];
  assign wd_expire = (TIMEOUT > 0) && (tcnt_q == TW'(TIMEOUT - 1));

  assign bus.gnt_id    = gnt_id_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_ptr   = ptr_q;

  // Round-robin scan: first active requester starting at ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < REQS; k++) begin
      idx = (int'(ptr_q) + k) % REQS;
      if (!found && active[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  // Next-state logic and all combinational outputs.
  always_comb begin
    state_d       = state_q;
    gnt_id_d      = gnt_id_q;
    ptr_d         = ptr_q;
    tcnt_d        = tcnt_q;
    bus.gnt_valid = 1'b0;
    bus.ramREN    = 1'b0;
    bus.ramWEN    = 1'b0;
    bus.ramaddr   = '0;
    bus.ramstore  = '0;
    bus.req_load  = '0;
    bus.req_wait  = '1;
    bus.req_err   = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_id_d = pick;
          tcnt_d   = '0;
          state_d  = XFER;
        end
      end

      XFER: begin
        bus.gnt_valid = 1'b1;
        bus.ramaddr   = bus.req_addr[gnt_id_q*ADDR_W +: ADDR_W];
        bus.ramstore  = bus.req_store[gnt_id_q*DATA_W +: DATA_W];
        bus.req_load[gnt_id_q*DATA_W +: DATA_W] = bus.ramload;
        if (!g_active) begin
          // Requester abandoned: release silently.
          ptr_d   = ptr_next;
          state_d = GAP;
        end else begin
          // Write wins when both enables are set.
          bus.ramWEN = bus.req_wen[gnt_id_q];
          bus.ramREN = bus.req_ren[gnt_id_q] & ~bus.req_wen[gnt_id_q];
          if (bus.ramstate == ST_ACCESS) begin
            bus.req_wait[gnt_id_q] = 1'b0;
            ptr_d   = ptr_next;
            state_d = GAP;
          end else if ((bus.ramstate == ST_ERROR) || wd_expire) begin
            bus.req_wait[gnt_id_q] = 1'b0;
            bus.req_err[gnt_id_q]  = 1'b1;
            ptr_d   = ptr_next;
            state_d = GAP;
          end else if (tcnt_q != '1) begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      GAP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      tcnt_q   <= tcnt_d;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter (REQS=4, TIMEOUT=8).
module tb_ram_port_arbiter;
  localparam int REQS    = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  ram_port_arbiter_if #(.REQS(REQS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_port_arbiter #(
    .REQS(REQS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // clock
  always #5 CLK = ~CLK;

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_err;
    logic [3:0] exp_wait;
    logic [1:0] order [5];
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

    bus.req_ren   = '0;
    bus.req_wen   = '0;
    bus.req_addr  = '0;
    bus.req_store = '0;
    bus.ramload   = '0;
    bus.ramstate  = S_FREE;

    // ---- reset values
    #3;
    chk("rst_gnt_valid", bus.gnt_valid, 1'b0);
    chk("rst_ramREN", bus.ramREN, 1'b0);
    chk("rst_ramWEN", bus.ramWEN, 1'b0);
    chk("rst_ramaddr", bus.ramaddr, 32'h0);
    chk("rst_ramstore", bus.ramstore, 32'h0);
    chk("rst_wait", bus.req_wait, 4'hF);
    chk("rst_load", bus.req_load, 128'h0);
    chk("rst_err", bus.req_err, 4'h0);
    chk("rst_state", bus.dbg_state, 2'd0);
    chk("rst_ptr", bus.dbg_ptr, 2'd0);
    next_cycle();
    RST = 1'b0;

    // ---- 1: single read by requester 2, ACCESS on 3rd XFER cycle
    bus.req_ren[2] = 1'b1;
    bus.req_addr[2*ADDR_W +: ADDR_W] = 32'h40;
    bus.ramstate = S_BUSY;
    #2;
    chk("t1_idle_ramREN", bus.ramREN, 1'b0);
    next_cycle(); #2;
    chk("t1_gnt_valid", bus.gnt_valid, 1'b1);
    chk("t1_gnt_id", bus.gnt_id, 2'd2);
    chk("t1_ramREN", bus.ramREN, 1'b1);
    chk("t1_ramaddr", bus.ramaddr, 32'h40);
    chk("t1_wait_busy", bus.req_wait, 4'hF);
    next_cycle(); #2;
    chk("t1_wait_busy2", bus.req_wait, 4'hF);
    next_cycle();
    bus.ramstate = S_ACCESS;
    bus.ramload  = 32'hDEAD_BEEF;
    #2;
    chk("t1_wait_access", bus.req_wait, 4'b1011);
    chk("t1_load", bus.req_load, {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0});
    chk("t1_err", bus.req_err, 4'h0);
    next_cycle();
    bus.req_ren  = '0;
    bus.ramstate = S_FREE;
    bus.ramload  = '0;
    #2;
    chk("t1_gap_state", bus.dbg_state, 2'd2);
    chk("t1_gap_ptr", bus.dbg_ptr, 2'd3);
    chk("t1_gap_ramREN", bus.ramREN, 1'b0);
    chk("t1_gap_wait", bus.req_wait, 4'hF);
    next_cycle(); #2;
    chk("t1_idle_state", bus.dbg_state, 2'd0);

    // ---- 2: all four hold requests from reset, ACCESS immediately
    RST = 1'b1;
    next_cycle();
    RST = 1'b0;
    bus.req_ren  = 4'hF;
    bus.ramstate = S_ACCESS;
    for (int n = 0; n < 5; n++) begin
      next_cycle(); #2;
      chk("t2_gnt_valid", bus.gnt_valid, 1'b1);
      chk("t2_gnt_id", bus.gnt_id, order[n]);
      exp_wait = 4'hF & ~(4'b0001 << order[n]);
      chk("t2_wait", bus.req_wait, exp_wait);
      next_cycle(); #2;
      chk("t2_gap", bus.dbg_state, 2'd2);
      next_cycle();
      if (n == 4) begin
        bus.req_ren  = '0;
        bus.ramstate = S_FREE;
      end
      #2;
      chk("t2_idle", bus.dbg_state, 2'd0);
    end
    chk("t2_ptr", bus.dbg_ptr, 2'd1);

    // ---- 3: read+write on requester 1, write wins
    bus.req_ren[1] = 1'b1;
    bus.req_wen[1] = 1'b1;
    bus.req_addr[1*ADDR_W +: ADDR_W]  = 32'h80;
    bus.req_store[1*DATA_W +: DATA_W] = 32'h1234;
    bus.ramstate = S_BUSY;
    next_cycle(); #2;
    chk("t3_ramWEN", bus.ramWEN, 1'b1);
    chk("t3_ramREN", bus.ramREN, 1'b0);
    chk("t3_ramstore", bus.ramstore, 32'h1234);
    chk("t3_ramaddr", bus.ramaddr, 32'h80);
    next_cycle();
    bus.ramstate = S_ACCESS;
    #2;
    chk("t3_wait", bus.req_wait, 4'b1101);
    next_cycle();
    bus.req_ren  = '0;
    bus.req_wen  = '0;
    bus.ramstate = S_FREE;
    next_cycle(); #2;
    chk("t3_ptr", bus.dbg_ptr, 2'd2);

    // ---- 4: watchdog with RAM held BUSY, requesters 2 and 3 waiting
    bus.req_ren  = 4'b1100;
    bus.ramstate = S_BUSY;
    for (int c = 1; c <= 8; c++) begin
      next_cycle(); #2;
      exp_err  = (c == 8) ? 4'b0100 : 4'b0000;
      exp_wait = (c == 8) ? 4'b1011 : 4'b1111;
      chk("t4_gnt_id", bus.gnt_id, 2'd2);
      chk("t4_err", bus.req_err, exp_err);
      chk("t4_wait", bus.req_wait, exp_wait);
    end
    next_cycle();
    bus.req_ren = 4'b1000;
    #2;
    chk("t4_gap_state", bus.dbg_state, 2'd2);
    chk("t4_gap_err", bus.req_err, 4'h0);
    chk("t4_ptr", bus.dbg_ptr, 2'd3);
    next_cycle();
    next_cycle(); #2;
    chk("t4_next_gnt", bus.gnt_id, 2'd3);
    chk("t4_next_err", bus.req_err, 4'h0);
    bus.ramstate = S_ACCESS;
    #1;
    chk("t4_next_wait", bus.req_wait, 4'b0111);
    next_cycle();
    bus.req_ren  = '0;
    bus.ramstate = S_FREE;
    next_cycle(); #2;
    chk("t4_ptr_wrap", bus.dbg_ptr, 2'd0);

    // ---- 5: ERROR on the 2nd XFER cycle
    bus.req_wen[0] = 1'b1;
    bus.req_addr[0 +: ADDR_W]  = 32'h100;
    bus.req_store[0 +: DATA_W] = 32'hCAFE;
    bus.ramstate = S_BUSY;
    next_cycle(); #2;
    chk("t5_ramWEN", bus.ramWEN, 1'b1);
    chk("t5_ramaddr", bus.ramaddr, 32'h100);
    chk("t5_err_c1", bus.req_err, 4'h0);
    next_cycle();
    bus.ramstate = S_ERROR;
    #2;
    chk("t5_err_c2", bus.req_err, 4'b0001);
    chk("t5_wait_c2", bus.req_wait, 4'b1110);
    next_cycle();
    bus.req_wen  = '0;
    bus.ramstate = S_FREE;
    #2;
    chk("t5_gap_state", bus.dbg_state, 2'd2);
    chk("t5_ptr", bus.dbg_ptr, 2'd1);
    chk("t5_gap_err", bus.req_err, 4'h0);
    next_cycle();

    // ---- 6: asynchronous reset during a write grant
    bus.req_wen  = 4'b0101;
    bus.ramstate = S_BUSY;
    next_cycle(); #2;
    chk("t6_pre_gnt", bus.gnt_id, 2'd2);
    chk("t6_pre_ramWEN", bus.ramWEN, 1'b1);
    RST = 1'b1;
    #1;
    chk("t6_rst_ramWEN", bus.ramWEN, 1'b0);
    chk("t6_rst_gnt_valid", bus.gnt_valid, 1'b0);
    chk("t6_rst_ptr", bus.dbg_ptr, 2'd0);
    chk("t6_rst_err", bus.req_err, 4'h0);
    chk("t6_rst_wait", bus.req_wait, 4'hF);
    next_cycle();
    RST = 1'b0;
    #2;
    chk("t6_idle", bus.dbg_state, 2'd0);
    next_cycle(); #2;
    chk("t6_post_gnt", bus.gnt_id, 2'd0);
    chk("t6_post_ramWEN", bus.ramWEN, 1'b1);
    bus.ramstate = S_ACCESS;
    #1;
    chk("t6_post_wait", bus.req_wait, 4'b1110);
    next_cycle();
    bus.req_wen  = '0;
    bus.ramstate = S_FREE;
    #2;
    chk("t6_post_ptr", bus.dbg_ptr, 2'd1);
    next_cycle();

    // ---- 7: requester abandons its request mid-transfer
    bus.req_ren[1] = 1'b1;
    bus.ramstate   = S_BUSY;
    next_cycle(); #2;
    chk("t7_ramREN", bus.ramREN, 1'b1);
    next_cycle();
    bus.req_ren = '0;
    #2;
    chk("t7_abandon_ramREN", bus.ramREN, 1'b0);
    chk("t7_abandon_wait", bus.req_wait, 4'hF);
    chk("t7_abandon_err", bus.req_err, 4'h0);
    next_cycle(); #2;
    chk("t7_gap_state", bus.dbg_state, 2'd2);
    chk("t7_ptr", bus.dbg_ptr, 2'd2);
    next_cycle();
    bus.ramstate = S_FREE;
    #2;
    chk("t7_idle", bus.dbg_state, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
